// File: rtl/fifo_reader_if.sv
// FIFO output-port handshake: the FIFO presents data with f2c_irdy,
// the consumer accepts it with c2f_trdy.
interface fifo_reader_if #(
    parameter int W = 3
);
    logic         f2c_irdy;
    logic [W-1:0] data_out;
    logic         c2f_trdy;

    modport master (
        output f2c_irdy,
        output data_out,
        input  c2f_trdy
    );

    modport slave (
        input  f2c_irdy,
        input  data_out,
        output c2f_trdy
    );
endinterface

// File: rtl/fifo_reader.sv
// Consumer endpoint that drains a FIFO, optionally throttles ready with an LFSR
// stall pattern, and checks every accepted entry against an incrementing sequence.
module fifo_reader #(
    parameter int          W           = 3,
    parameter int          CNT_W       = 16,
    parameter int          STALL_EN    = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    fifo_reader_if.slave     fifo,
    input  logic             enable,
    output logic [CNT_W-1:0] rcv_count,
    output logic [W-1:0]     expected,
    output logic             err,
    output logic [W-1:0]     bad_data,
    output logic [CNT_W-1:0] bad_index,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic             STALL_ON = (STALL_EN != 0);
    localparam logic             STOP_ERR = (STOP_ON_ERR != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [15:0]      LFSR_MSK = 16'hB400;

    state_t           state_r;
    state_t           state_nx_s;
    logic [15:0]      lfsr_r;
    logic [15:0]      lfsr_nx_s;
    logic             trdy_r;
    logic             trdy_nx_s;
    logic             halted_r;
    logic [W-1:0]     expected_r;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic [W-1:0]     bad_data_r;
    logic [CNT_W-1:0] bad_index_r;
    logic             xfer_s;
    logic             mismatch_s;

    // Galois right-shift step: fold the mask back in when a one falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MSK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    assign xfer_s     = fifo.f2c_irdy & trdy_r;
    assign mismatch_s = xfer_s & (fifo.data_out != expected_r);

    // Next state and next LFSR value; the LFSR only advances while running.
    always_comb begin
        state_nx_s = state_r;
        lfsr_nx_s  = lfsr_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                lfsr_nx_s = lfsr_step(lfsr_r);
                if (mismatch_s && STOP_ERR) begin
                    state_nx_s = ST_HALT;
                end else if (!enable) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALT: begin
                state_nx_s = ST_HALT;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Ready is precomputed from next-cycle state so the port comes straight off a flop.
    always_comb begin
        trdy_nx_s = (state_nx_s == ST_RUN) && !(STALL_ON && lfsr_nx_s[0]);
    end

    // FSM, stall LFSR, transfer counter and first-mismatch capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            lfsr_r      <= LFSR_SEED;
            trdy_r      <= 1'b0;
            halted_r    <= 1'b0;
            expected_r  <= {W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            bad_data_r  <= {W{1'b0}};
            bad_index_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            lfsr_r   <= lfsr_nx_s;
            trdy_r   <= trdy_nx_s;
            halted_r <= (state_nx_s == ST_HALT);
            if (xfer_s) begin
                // The reference keeps counting on its own even after a bad entry.
                expected_r <= expected_r + W'(1'b1);
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                end
                if (mismatch_s && !err_r) begin
                    err_r       <= 1'b1;
                    bad_data_r  <= fifo.data_out;
                    bad_index_r <= cnt_r;
                end
            end
        end
    end

    assign fifo.c2f_trdy = trdy_r;
    assign rcv_count     = cnt_r;
    assign expected      = expected_r;
    assign err           = err_r;
    assign bad_data      = bad_data_r;
    assign bad_index     = bad_index_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a no-stall/stop-on-error instance and a stalling/continue
// instance run side by side against a transaction-level reference model.
module tb_fifo_reader;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    fifo_reader_if #(.W(3)) ifa ();
    fifo_reader_if #(.W(3)) ifb ();

    logic [3:0]  cnt_a, bi_a;
    logic [15:0] cnt_b, bi_b;
    logic [2:0]  exp_a, exp_b, bd_a, bd_b;
    logic        err_a, err_b, hlt_a, hlt_b;

    fifo_reader #(.W(3), .CNT_W(4), .STALL_EN(0), .LFSR_SEED(16'hACE1), .STOP_ON_ERR(1)) dut_a (
        .clk(clk), .rst(rst), .fifo(ifa), .enable(enable),
        .rcv_count(cnt_a), .expected(exp_a), .err(err_a),
        .bad_data(bd_a), .bad_index(bi_a), .halted(hlt_a)
    );

    fifo_reader #(.W(3), .CNT_W(16), .STALL_EN(1), .LFSR_SEED(16'hACE1), .STOP_ON_ERR(0)) dut_b (
        .clk(clk), .rst(rst), .fifo(ifb), .enable(enable),
        .rcv_count(cnt_b), .expected(exp_b), .err(err_b),
        .bad_data(bd_b), .bad_index(bi_b), .halted(hlt_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state, one slot per instance.
    int          stall_cfg [2] = '{0, 1};
    int          stop_cfg  [2] = '{1, 0};
    int          cmax      [2] = '{15, 65535};
    int          m_mode [2];
    logic [15:0] m_lfsr [2];
    int          m_exp  [2];
    int          m_cnt  [2];
    int          m_err  [2];
    int          m_bd   [2];
    int          m_bi   [2];
    int          m_src  [2];
    int          sub_k;
    int          sub_v;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int m_rdy(input int i);
        return (m_mode[i] == M_RUN && !(stall_cfg[i] != 0 && m_lfsr[i][0])) ? 1 : 0;
    endfunction

    function automatic int src_data(input int i);
        return (m_src[i] == sub_k) ? sub_v : (m_src[i] % 8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_lfsr[i] = 16'hACE1; m_exp[i] = 0; m_cnt[i] = 0;
            m_err[i] = 0; m_bd[i] = 0; m_bi[i] = 0; m_src[i] = 0;
        end
        sub_k = -1;
        sub_v = 0;
    endtask

    task automatic model_step(input int i, input int en, input int iv, input int d);
        int xf;
        int mis;
        xf  = m_rdy(i) & iv;
        mis = (xf != 0 && d != m_exp[i]) ? 1 : 0;
        if (xf != 0) begin
            if (mis != 0 && m_err[i] == 0) begin
                m_err[i] = 1; m_bd[i] = d; m_bi[i] = m_cnt[i];
            end
            m_exp[i] = (m_exp[i] + 1) % 8;
            if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            m_src[i] = m_src[i] + 1;
        end
        if (m_mode[i] == M_RUN) begin
            m_lfsr[i] = lfsr_adv(m_lfsr[i]);
            if (mis != 0 && stop_cfg[i] != 0) m_mode[i] = M_HALT;
            else if (en == 0)                 m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_IDLE && en != 0) begin
            m_mode[i] = M_RUN;
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s[%0d] got %0d expected %0d", tag, i, obs, want);
        end
    endtask

    task automatic check_all();
        chk("trdy",      0, 32'(ifa.c2f_trdy), m_rdy(0));
        chk("expected",  0, 32'(exp_a),        m_exp[0]);
        chk("rcv_count", 0, 32'(cnt_a),        m_cnt[0]);
        chk("err",       0, 32'(err_a),        m_err[0]);
        chk("bad_data",  0, 32'(bd_a),         m_bd[0]);
        chk("bad_index", 0, 32'(bi_a),         m_bi[0]);
        chk("halted",    0, 32'(hlt_a),        (m_mode[0] == M_HALT) ? 1 : 0);
        chk("trdy",      1, 32'(ifb.c2f_trdy), m_rdy(1));
        chk("expected",  1, 32'(exp_b),        m_exp[1]);
        chk("rcv_count", 1, 32'(cnt_b),        m_cnt[1]);
        chk("err",       1, 32'(err_b),        m_err[1]);
        chk("bad_data",  1, 32'(bd_b),         m_bd[1]);
        chk("bad_index", 1, 32'(bi_b),         m_bi[1]);
        chk("halted",    1, 32'(hlt_b),        (m_mode[1] == M_HALT) ? 1 : 0);
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cycle(input int en, input int irdy_pct);
        int iv [2];
        int d  [2];
        @(negedge clk);
        enable = (en != 0);
        for (int i = 0; i < 2; i++) begin
            iv[i] = (int'($urandom_range(99)) < irdy_pct) ? 1 : 0;
            d[i]  = (iv[i] != 0) ? src_data(i) : int'($urandom_range(7));
        end
        ifa.f2c_irdy = (iv[0] != 0); ifa.data_out = 3'(d[0]);
        ifb.f2c_irdy = (iv[1] != 0); ifb.data_out = 3'(d[1]);
        check_all();
        for (int i = 0; i < 2; i++) model_step(i, en, iv[i], d[i]);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0;
        ifa.f2c_irdy = 1'b0; ifb.f2c_irdy = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        ifa.f2c_irdy = 1'b0; ifa.data_out = 3'd0;
        ifb.f2c_irdy = 1'b0; ifb.data_out = 3'd0;
        model_reset();
        do_reset();

        // Streaming: ready from the first RUN cycle on A, seed forces a stall on B.
        cycle(1, 100);
        #1;
        chk("first_trdy", 0, 32'(ifa.c2f_trdy), 32'd1);
        chk("first_trdy", 1, 32'(ifb.c2f_trdy), 32'd0);
        repeat (10) cycle(1, 100);
        #1;
        chk("stream_cnt", 0, 32'(cnt_a), 32'd10);
        chk("stream_exp", 0, 32'(exp_a), 32'd2);
        chk("stream_err", 0, 32'(err_a), 32'd0);

        // Enable toggling: last RUN transfer counts, ready drops, then resumes.
        cycle(0, 100);
        #1;
        chk("drop_trdy", 0, 32'(ifa.c2f_trdy), 32'd0);
        chk("drop_cnt",  0, 32'(cnt_a),        32'd11);
        repeat (3) cycle(0, 100);
        repeat (6) cycle(1, 100);
        #1;
        chk("resume_exp", 0, 32'(exp_a), 32'd0);
        chk("resume_cnt", 0, 32'(cnt_a), 32'd15);
        chk("resume_err", 0, 32'(err_a), 32'd0);

        // Stalls: 1000 cycles of random valid against the reference LFSR.
        do_reset();
        repeat (1000) cycle(1, 60);
        #1;
        chk("stall_err", 1, 32'(err_b), 32'd0);
        chk("stall_cnt", 1, 32'(cnt_b), m_cnt[1]);

        // Saturation of the 4-bit counter.
        do_reset();
        repeat (21) cycle(1, 100);
        #1;
        chk("sat_cnt", 0, 32'(cnt_a), 32'd15);
        chk("sat_exp", 0, 32'(exp_a), 32'd4);

        // Mismatch: 0,1,5,3 halts A; B keeps going and keeps its first capture.
        do_reset();
        sub_k = 2; sub_v = 5;
        repeat (5) cycle(1, 100);
        #1;
        chk("mis_err",   0, 32'(err_a),        32'd1);
        chk("mis_bdata", 0, 32'(bd_a),         32'd5);
        chk("mis_bidx",  0, 32'(bi_a),         32'd2);
        chk("mis_cnt",   0, 32'(cnt_a),        32'd3);
        chk("mis_halt",  0, 32'(hlt_a),        32'd1);
        chk("mis_trdy",  0, 32'(ifa.c2f_trdy), 32'd0);
        repeat (5) cycle(1, 100);
        sub_k = m_src[1] + 3;
        sub_v = (sub_k + 4) % 8;
        repeat (40) cycle(1, 70);
        #1;
        chk("halt_cnt",  0, 32'(cnt_a), 32'd3);
        chk("halt_hold", 0, 32'(hlt_a), 32'd1);
        chk("mis_err",   1, 32'(err_b), 32'd1);
        chk("mis_bdata", 1, 32'(bd_b),  32'd5);
        chk("mis_bidx",  1, 32'(bi_b),  32'd2);

        // Reset asserted between edges while A is mid-transfer.
        do_reset();
        repeat (4) cycle(1, 100);
        #2;
        rst = 1'b1; enable = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_trdy", 0, 32'(ifa.c2f_trdy), 32'd0);
        chk("rst_cnt",  0, 32'(cnt_a),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        ifa.f2c_irdy = 1'b0; ifb.f2c_irdy = 1'b0;
        repeat (4) cycle(1, 100);
        #1;
        chk("restart_exp", 0, 32'(exp_a), 32'd3);
        chk("restart_err", 0, 32'(err_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
